// File: rtl/cfg_req_pkg.sv
// Shared types and codes for the user configuration-space requester.
// Status codes here are the values reported on resp_err.
package cfg_req_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RETRY   = 2'b10;

  // User configuration registers start at this dword (byte address 0x80).
  localparam logic [5:0] USER_CFG_DW = 6'h20;

  function automatic logic [31:0] cfg_dw_to_byte(input logic [5:0] dw);
    return {24'h0, dw, 2'b00};
  endfunction

endpackage

// File: rtl/cfg_req_gen.sv
// Turns one read/write command into an address phase plus data phase toward a user config responder.
// Zero-wait responder: accept T, resp_valid T+4; req_ready is high only in IDLE, so commands are held off while busy.
module cfg_req_gen
  import cfg_req_pkg::*;
#(
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 3
) (
  input  logic        CLK,
  input  logic        RST_I,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        cfg_hit,
  output logic        cfg_vld,
  output logic        s_wrdn,
  output logic        s_data,
  output logic        s_data_vld,
  output logic [31:0] addr,
  output logic [31:0] adio_out,
  input  logic [31:0] adio_in,
  input  logic        c_ready,
  input  logic        c_term
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_LAST = RW'(MAX_RETRY);

  state_t          r_state;
  logic            r_wr;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [1:0]      r_err;
  logic [TW-1:0]   r_tmo_cnt;
  logic [RW-1:0]   r_rty_cnt;

  state_t          w_state_nxt;
  logic [1:0]      w_err_nxt;
  logic [31:0]     w_rdata_nxt;
  logic [TW-1:0]   w_tmo_nxt;
  logic [RW-1:0]   w_rty_nxt;
  logic            w_accept;

  assign req_ready = (r_state == IDLE) && !RST_I;
  assign w_accept  = req_valid && req_ready;
  assign addr      = r_addr;

  always_ff @(posedge CLK) begin
    if (RST_I) begin
      r_state   <= IDLE;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= ERR_OK;
      r_tmo_cnt <= '0;
      r_rty_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err     <= w_err_nxt;
      r_rdata   <= w_rdata_nxt;
      r_tmo_cnt <= w_tmo_nxt;
      r_rty_cnt <= w_rty_nxt;
      if (w_accept) begin
        r_wr    <= req_wr;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
    end
  end

  // Termination priority within DATA: success, then retry, then timeout.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    w_rdata_nxt = r_rdata;
    w_tmo_nxt   = r_tmo_cnt;
    w_rty_nxt   = r_rty_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_rty_nxt   = '0;
          w_err_nxt   = ERR_OK;
          w_rdata_nxt = '0;
          w_state_nxt = ADDR;
        end
      end
      ADDR: begin
        w_tmo_nxt   = '0;
        w_state_nxt = DATA;
      end
      DATA: begin
        if (c_ready && c_term) begin
          w_err_nxt = ERR_OK;
          if (!r_wr) begin
            w_rdata_nxt = adio_in;
          end
          w_state_nxt = DONE;
        end else if (c_term) begin
          if (r_rty_cnt == RTY_LAST) begin
            w_err_nxt   = ERR_RETRY;
            w_state_nxt = DONE;
          end else begin
            w_rty_nxt   = r_rty_cnt + 1'b1;
            w_state_nxt = ADDR;
          end
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = DONE;
        end else begin
          w_tmo_nxt = r_tmo_cnt + 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // DONE drops s_data so the responder can release its access flags.
  always_comb begin
    cfg_hit    = 1'b0;
    cfg_vld    = 1'b0;
    s_wrdn     = 1'b0;
    s_data     = 1'b0;
    s_data_vld = 1'b0;
    adio_out   = '0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = ERR_OK;
    unique case (r_state)
      ADDR: begin
        cfg_hit = 1'b1;
        cfg_vld = 1'b1;
        s_wrdn  = r_wr;
      end
      DATA: begin
        s_data     = 1'b1;
        s_wrdn     = r_wr;
        s_data_vld = r_wr;
        adio_out   = r_wr ? r_wdata : '0;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (!r_wr && (r_err == ERR_OK)) ? r_rdata : '0;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: doc/cfg_req_gen.md
Name: cfg_req_gen

Overview:
Simulation-side configuration-access requester that drives the user-side configuration interface of the PCI target core.
- Converts a simple request/response command (read/write, address, data) into the cfg_hit / cfg_vld / s_data / s_data_vld sequencing a user configuration responder expects.
- Waits for c_ready/c_term, captures read data and reports completion status.
- Used by the irun bench to exercise user configuration registers (dword 0x20, byte address 0x80) and their wait/terminate behaviour.

Parameters:
TIMEOUT, 16, data-phase cycles without termination before abort (counter width = $clog2(TIMEOUT+1))
MAX_RETRY, 3, retries allowed after c_term without c_ready before abort

Ports:
CLK  in  1  clock
RST_I  in  1  synchronous active-high reset
req_valid  in  1  command request
req_ready  out  1  high in IDLE only; accept = req_valid & req_ready
req_wr  in  1  1 = write, 0 = read
req_addr  in  32  configuration byte address
req_wdata  in  32  write data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  read data (0 for writes and errors)
resp_err  out  2  00 ok, 01 timeout, 10 retry exhausted
cfg_hit  out  1  address-phase strobe
cfg_vld  out  1  configuration-valid strobe, coincident with cfg_hit
s_wrdn  out  1  direction, valid with cfg_hit and through data phase
s_data  out  1  data phase active
s_data_vld  out  1  write data valid on adio_out
addr  out  32  latched request address
adio_out  out  32  write data toward responder
adio_in  in  32  read data from responder; may be Z when not driven
c_ready  in  1  responder ready
c_term  in  1  responder terminate

Behaviour:
- Interface: one clock CLK; reset RST_I is synchronous, active-high.
- Reset values: req_ready=0 during reset, 1 from the first cycle after reset. All other outputs are 0. FSM goes to IDLE; timeout and retry counters clear.
- States: IDLE, ADDR, DATA, DONE.
- IDLE:
  - On accept, latch wr/addr/wdata, clear retry_cnt, go ADDR.
  - req_valid in any other state is ignored.
- ADDR (exactly 1 cycle):
  - cfg_hit=1, cfg_vld=1, s_wrdn=wr, addr driven, s_data=0.
  - Clear timeout_cnt. Go DATA.
- DATA:
  - s_data=1, s_wrdn=wr.
  - For writes: s_data_vld=1 and adio_out=wdata every DATA cycle. For reads: s_data_vld=0, adio_out=0.
  - c_ready & c_term: capture adio_in into resp_rdata if read (X/Z bits captured as-is). Set err=00. Go DONE.
  - c_term & !c_ready (retry):
    - If retry_cnt == MAX_RETRY: err=10, go DONE.
    - Else: retry_cnt+1, go ADDR (s_data drops for that cycle).
  - c_ready & !c_term: not a termination; stay in DATA.
  - Otherwise timeout_cnt+1. When timeout_cnt reaches TIMEOUT-1 with no termination: err=01, go DONE.
  - Priority on the same edge: success > retry > timeout.
- DONE (1 cycle):
  - s_data=0, which lets the responder clear its access flags.
  - resp_valid=1 with resp_rdata/resp_err. Go IDLE.
  - resp_rdata is forced to 0 on writes and on errors.
- Latency with a zero-wait responder (registered c_ready one cycle after s_data): accept at cycle T, ADDR T+1, DATA T+2..T+3, resp_valid at T+4.
- Back-to-back: next accept is possible in the IDLE cycle after DONE (minimum 5-cycle command period).
- Reset mid-operation: immediate return to IDLE with reset output values; no resp_valid is issued for the aborted command.

Decomposition:
- Package cfg_req_pkg:
  - state enum (IDLE, ADDR, DATA, DONE)
  - resp_err codes: ERR_OK=2'b00, ERR_TIMEOUT=2'b01, ERR_RETRY=2'b10
  - USER_CFG_DW=6'h20
- Single module. The timeout/retry counters are small enough to live inline; no sub-module.

Test Plan:
- Write 0x80 data 0xDEADBEEF with zero-wait responder -> cfg_hit/cfg_vld one cycle with s_wrdn=1; s_data_vld=1 with adio_out=0xDEADBEEF during DATA; resp_valid at T+4, resp_err=00, resp_rdata=0.
- Read 0x80 after the above write -> s_wrdn=0, s_data_vld=0; resp_rdata=0xDEADBEEF, resp_err=00, resp_valid at T+4.
- Read 0x40 (non-user register) -> responder terminates immediately; resp_err=00, completion at T+4.
- Responder never asserts c_ready/c_term -> resp_err=01 after TIMEOUT=16 DATA cycles, s_data low in DONE, FSM back in IDLE.
- Responder answers c_term without c_ready 4 times -> 3 re-issued address phases, then resp_err=10. Same stimulus with success on the 3rd attempt -> resp_err=00.
- RST_I asserted for 1 cycle during DATA -> next cycle all outputs 0, no resp_valid, req_ready=1 the cycle after reset deasserts; a new read completes normally.
